param_nfa_matcher: RTL
======================

Name: param_nfa_matcher

Overview:
Streaming multi-pattern string matcher using one shift-and NFA state vector per pattern, all advanced in parallel on each accepted input character. It is the parametrised successor of the fixed-size parallel NFA System. Additions over that System: run-time pattern loading, variable pattern lengths, a wildcard character, a case-insensitive mode, and valid/ready handshakes on both the input stream and the match-report output. It sits between a character source (file/DMA reader) and a match-report consumer.

Parameters:
DWIDTH, 8, character width in bits
PAT_NUM, 4, number of patterns matched in parallel
PAT_LEN, 8, maximum characters per pattern (NFA states per pattern)
CNT_W, 16, width of the stream position counter
WILDCARD, 8'h3F, pattern character that matches any input character

Ports:
clk  in  1  clock; all logic is rising-edge
reset  in  1  asynchronous, active-high; clears all state
cfg_we  in  1  write one pattern character
cfg_pat  in  $clog2(PAT_NUM)  pattern select for cfg writes
cfg_idx  in  $clog2(PAT_LEN)  character index within pattern
cfg_char  in  DWIDTH  character value
cfg_len_we  in  1  write pattern length
cfg_len  in  $clog2(PAT_LEN)+1  pattern length, 0..PAT_LEN
nocase  in  1  case-insensitive compare; sampled at start
start  in  1  begin a new stream
s_valid  in  1  input character valid
s_ready  out  1  matcher accepts a character this cycle
s_data  in  DWIDTH  input character
s_last  in  1  final character of the stream
m_valid  out  1  match report valid
m_ready  in  1  consumer accepts the report
m_match  out  PAT_NUM  bit p set = pattern p ends at m_pos
m_pos  out  CNT_W  0-based stream index of the character that completed the match(es)
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at end of stream

Behaviour:
- Reset values: all outputs 0. Pattern RAM, lengths, NFA vectors and position counter are 0. FSM resets to IDLE.
- FSM states and transitions:
  - IDLE: start=1 clears NFA vectors and position counter, latches nocase, and moves to RUN.
  - RUN: on accepting a character with s_last=1, move to DRAIN.
  - DRAIN: once m_valid=0, or when m_valid && m_ready, assert done for one cycle and return to IDLE.
- start outside IDLE is ignored.
- cfg_we / cfg_len_we are honoured only in IDLE. Writes in other states are dropped. cfg_we and cfg_len_we in the same cycle are both honoured.
- Input acceptance:
  - s_ready = (state==RUN) && (!m_valid || m_ready).
  - A character is accepted when s_valid && s_ready. Nothing changes otherwise.
- NFA update, per accepted character c and pattern p:
  - eq_p[i] = (i < len_p) && (pat_p[i]==WILDCARD || fold(pat_p[i])==fold(c)).
  - S_p <= ((S_p << 1) | 1) & eq_p.
  - fold(x) maps 8'h41..8'h5A to x+8'h20 when the latched nocase=1, and is identity otherwise. Folding acts on the low 8 bits only.
  - hit_p = (len_p != 0) && next_S_p[len_p-1].
  - A pattern with len=0 never matches.
  - Overlapping matches are all reported (e.g. pattern "aa" on "aaa" hits at positions 1 and 2).
- Reporting:
  - If any hit_p on an accepted character, the next cycle has m_valid=1, m_match=hit vector, m_pos=current position.
  - Latency is 1 cycle from accept to report.
  - m_valid, m_match and m_pos are held stable until m_ready.
  - A new report loaded in the same cycle as a drain replaces the old one without a bubble.
  - A character with no hit clears m_valid only if the old report drains in the same cycle.
- Position counter: increments by 1 per accepted character and wraps modulo 2^CNT_W.
- Reset mid-stream returns to IDLE and erases patterns; software must reload them.

Test Plan:
1. Load p0="abc" (len 3), p1="bc" (len 2); stream "xabcab" with m_ready=1 -> a single report with m_match=4'b0011, m_pos=3; done pulses one cycle after the last accept.
2. p0="a?c" with WILDCARD; stream "azcabc" -> reports at m_pos=2 and 5, both with m_match=4'b0001.
3. p0="AB", nocase=1; stream "ab" -> hit at pos 1. Rerun with nocase=0 -> no report; done still pulses.
4. p0="aa"; stream "aaaa" with m_ready held 0 for 5 cycles -> s_ready drops after the first report. Release m_ready -> reports at pos 1, 2 and 3 in order, none lost.
5. cfg_len=0 for p2 with characters loaded -> p2 never hits. cfg_we during RUN -> pattern unchanged on the next stream.
6. Assert reset mid-stream -> all outputs 0 on the same edge, state IDLE. A later start with no reload produces no matches.

Source files
------------

// File: rtl/param_nfa_matcher.sv
`default_nettype none
// ============================================================================
// Module   : param_nfa_matcher
// Purpose  : Streaming multi-pattern string matcher. Each pattern has one
//            shift-and NFA state vector. All vectors advance in parallel on
//            every accepted input character. Patterns and their lengths are
//            loaded at run time while the matcher is idle. The matcher also
//            supports a wildcard character and a case-insensitive mode.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   cfg_we/pat/idx/char   write one pattern character (honoured in IDLE only)
//   cfg_len_we/cfg_len    write one pattern length 0..PAT_LEN (IDLE only)
//   nocase                case-insensitive compare, latched by start
//   start                 begin a new stream (ignored outside IDLE)
//   s_valid/ready/data/last   input character stream
//   m_valid/ready/match/pos   match report stream (m_pos = completing index)
//   busy                  high while streaming or draining
//   done                  one-cycle pulse when the stream has fully drained
// ============================================================================
module param_nfa_matcher #(
  parameter int                DWIDTH   = 8,
  parameter int                PAT_NUM  = 4,
  parameter int                PAT_LEN  = 8,
  parameter int                CNT_W    = 16,
  parameter logic [DWIDTH-1:0] WILDCARD = 'h3F
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(PAT_NUM)-1:0] cfg_pat,
  input  logic [$clog2(PAT_LEN)-1:0] cfg_idx,
  input  logic [DWIDTH-1:0]          cfg_char,
  input  logic                       cfg_len_we,
  input  logic [$clog2(PAT_LEN):0]   cfg_len,
  input  logic                       nocase,
  input  logic                       start,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DWIDTH-1:0]          s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PAT_NUM-1:0]         m_match,
  output logic [CNT_W-1:0]           m_pos,
  output logic                       busy,
  output logic                       done
);

  localparam int PW = $clog2(PAT_NUM);
  localparam int IW = $clog2(PAT_LEN);
  localparam int LW = IW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_nocase;
  logic [CNT_W-1:0]   r_pos;
  logic               w_idle;
  logic               w_start_go;
  logic               w_accept;
  logic [DWIDTH-1:0]  w_in_fold;
  logic [PAT_NUM-1:0] w_hit;

  // Only the low byte is folded. Upper bits of wider characters pass through
  // unchanged, so a case-insensitive compare still distinguishes them.
  function automatic logic [DWIDTH-1:0] fold(input logic [DWIDTH-1:0] x,
                                             input logic              nc);
    logic [DWIDTH-1:0] y;
    y = x;
    if (nc && (x[7:0] >= 8'h41) && (x[7:0] <= 8'h5A)) begin
      y[7:0] = x[7:0] + 8'h20;
    end
    return y;
  endfunction

  assign w_idle     = (r_state == ST_IDLE);
  assign w_start_go = w_idle && start;
  // A character may only enter if its possible report has a free slot:
  // the report register is empty or is draining in this same cycle.
  assign s_ready    = (r_state == ST_RUN) && (!m_valid || m_ready);
  assign w_accept   = s_valid && s_ready;
  assign busy       = (r_state != ST_IDLE);
  assign w_in_fold  = fold(s_data, r_nocase);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept && s_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Finish only when no report is left pending after this cycle.
        if (!m_valid || m_ready) begin
          done        = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Stream context: latched case mode and position counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nocase <= 1'b0;
      r_pos    <= '0;
    end else if (w_start_go) begin
      r_nocase <= nocase;
      r_pos    <= '0;
    end else if (w_accept) begin
      r_pos    <= r_pos + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-pattern storage and NFA
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < PAT_NUM; p++) begin : g_pat
    logic [DWIDTH-1:0]  r_chars [PAT_LEN];
    logic [LW-1:0]      r_len;
    logic [PAT_LEN-1:0] r_nfa;
    logic [PAT_LEN-1:0] w_eq;
    logic [PAT_LEN-1:0] w_nfa_nxt;
    logic               w_hit_p;
    logic               w_sel;

    // Out-of-range pattern selects simply match no block.
    assign w_sel = w_idle && (cfg_pat == PW'(p));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < PAT_LEN; i++) begin
          r_chars[i] <= '0;
        end
        r_len <= '0;
        r_nfa <= '0;
      end else begin
        if (cfg_we && w_sel) begin
          for (int i = 0; i < PAT_LEN; i++) begin
            if (cfg_idx == IW'(i)) begin
              r_chars[i] <= cfg_char;
            end
          end
        end
        if (cfg_len_we && w_sel) begin
          r_len <= cfg_len;
        end
        if (w_start_go) begin
          r_nfa <= '0;
        end else if (w_accept) begin
          r_nfa <= w_nfa_nxt;
        end
      end
    end

    always_comb begin
      w_eq    = '0;
      w_hit_p = 1'b0;
      for (int i = 0; i < PAT_LEN; i++) begin
        w_eq[i] = (LW'(i) < r_len) &&
                  ((r_chars[i] == WILDCARD) ||
                   (fold(r_chars[i], r_nocase) == w_in_fold));
      end
      // Shift-and step: bit i set means the first i+1 pattern characters
      // end at the current input character.
      w_nfa_nxt = ((r_nfa << 1) | PAT_LEN'(1)) & w_eq;
      // The final-state bit is selected by comparison, which keeps the index
      // in range for any length value, including 0 (which never matches).
      for (int i = 0; i < PAT_LEN; i++) begin
        if (r_len == LW'(i + 1)) begin
          w_hit_p = w_nfa_nxt[i];
        end
      end
    end

    assign w_hit[p] = w_hit_p;
  end

  // --------------------------------------------------------------------------
  // Match report register
  // --------------------------------------------------------------------------
  // A load can never overwrite an undrained report because acceptance is
  // gated by s_ready. A load in the same cycle as a drain therefore replaces
  // the old report back to back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_match <= '0;
      m_pos   <= '0;
    end else if (w_accept && (|w_hit)) begin
      m_valid <= 1'b1;
      m_match <= w_hit;
      m_pos   <= r_pos;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
